// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS-subset sequencer: state codes,
// opcodes, ALU/mux select codes and the bundled control-word type.
package mc_pkg;

   typedef logic [3:0] state_t;

   localparam state_t FETCH   = 4'd0;
   localparam state_t DECODE  = 4'd1;
   localparam state_t MEMADR  = 4'd2;
   localparam state_t MEMRD   = 4'd3;
   localparam state_t MEMWB   = 4'd4;
   localparam state_t MEMWR   = 4'd5;
   localparam state_t EXEC_R  = 4'd6;
   localparam state_t RWB     = 4'd7;
   localparam state_t EXEC_I  = 4'd8;
   localparam state_t IWB     = 4'd9;
   localparam state_t BRANCH  = 4'd10;
   localparam state_t JUMP    = 4'd11;
   localparam state_t ILLEGAL = 4'd12;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b010;
   localparam logic [2:0] ALU_RTYPE = 3'b100;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       PCWr;
      logic       PCWrCond;
      logic       IorD;
      logic       MemRd;
      logic       MemWr;
      logic       IRWr;
      logic       RegDst;
      logic       MemtoReg;
      logic       RegWr;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [2:0] ALUop;
      logic       ExtOp;
      logic [1:0] PCSrc;
      logic       R_type;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the sequencer (master) and the datapath/memory side (slave).
interface multicycle_control_if;
   import mc_pkg::*;

   logic [31:0] instru;
   logic        mem_ready;
   logic        PCWr;
   logic        PCWrCond;
   logic        IorD;
   logic        MemRd;
   logic        MemWr;
   logic        IRWr;
   logic        RegDst;
   logic        MemtoReg;
   logic        RegWr;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [2:0]  ALUop;
   logic        ExtOp;
   logic [1:0]  PCSrc;
   logic        R_type;
   logic        illegal_op;
   state_t      state;

   modport master (
      input  instru, mem_ready,
      output PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, MemtoReg, RegWr,
             ALUSrcA, ALUSrcB, ALUop, ExtOp, PCSrc, R_type, illegal_op, state
   );

   modport slave (
      output instru, mem_ready,
      input  PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, MemtoReg, RegWr,
             ALUSrcA, ALUSrcB, ALUop, ExtOp, PCSrc, R_type, illegal_op, state
   );

endinterface

// File: rtl/mc_outdecode.sv
// Combinational control-word decode from (state, opcode, mem_ready).
module mc_outdecode
   import mc_pkg::*;
(
   input  state_t     state_i,
   input  logic [5:0] op_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         FETCH: begin
            ctrl_o.MemRd   = 1'b1;
            ctrl_o.ALUSrcB = SRCB_FOUR;
            ctrl_o.ALUop   = ALU_ADD;
            ctrl_o.PCSrc   = PCSRC_ALU;
            // IR and PC commit only in the cycle memory returns the word
            ctrl_o.IRWr    = mem_ready_i;
            ctrl_o.PCWr    = mem_ready_i;
         end
         DECODE: begin
            ctrl_o.ALUSrcB = SRCB_IMM_SH2;
            ctrl_o.ExtOp   = 1'b1;
            ctrl_o.ALUop   = ALU_ADD;
         end
         MEMADR: begin
            ctrl_o.ALUSrcA = 1'b1;
            ctrl_o.ALUSrcB = SRCB_IMM;
            ctrl_o.ExtOp   = 1'b1;
            ctrl_o.ALUop   = ALU_ADD;
         end
         MEMRD: begin
            ctrl_o.MemRd = 1'b1;
            ctrl_o.IorD  = 1'b1;
         end
         MEMWB: begin
            ctrl_o.RegWr    = 1'b1;
            ctrl_o.MemtoReg = 1'b1;
         end
         MEMWR: begin
            ctrl_o.MemWr = 1'b1;
            ctrl_o.IorD  = 1'b1;
         end
         EXEC_R: begin
            ctrl_o.ALUSrcA = 1'b1;
            ctrl_o.ALUSrcB = SRCB_RT;
            ctrl_o.ALUop   = ALU_RTYPE;
            ctrl_o.R_type  = 1'b1;
         end
         RWB: begin
            ctrl_o.RegWr  = 1'b1;
            ctrl_o.RegDst = 1'b1;
         end
         EXEC_I: begin
            ctrl_o.ALUSrcA = 1'b1;
            ctrl_o.ALUSrcB = SRCB_IMM;
            ctrl_o.ExtOp   = (op_i != OP_ORI);
            ctrl_o.ALUop   = (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
         end
         IWB: begin
            ctrl_o.RegWr = 1'b1;
         end
         BRANCH: begin
            ctrl_o.ALUSrcA  = 1'b1;
            ctrl_o.ALUSrcB  = SRCB_RT;
            ctrl_o.ALUop    = ALU_SUB;
            ctrl_o.PCWrCond = 1'b1;
            ctrl_o.PCSrc    = PCSRC_ALUOUT;
         end
         JUMP: begin
            ctrl_o.PCWr  = 1'b1;
            ctrl_o.PCSrc = PCSRC_JUMP;
         end
         ILLEGAL: begin
            ctrl_o.illegal_op = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: state register and next-state logic; outputs come
// from mc_outdecode and are forced low whenever reset is asserted.
module multicycle_control
   import mc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus
);

   state_t     state_q, state_d;
   logic [5:0] op;
   ctrl_t      ctrl, ctrl_g;
   logic       unused_instru_bits;

   assign op                 = bus.instru[31:26];
   assign unused_instru_bits = ^bus.instru[25:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:     state_d = MEMADR;
               OP_R:             state_d = EXEC_R;
               OP_ORI, OP_ADDIU: state_d = EXEC_I;
               OP_BEQ:           state_d = BRANCH;
               OP_J:             state_d = JUMP;
               default:          state_d = ILLEGAL;
            endcase
         end
         MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
         MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
         EXEC_R: state_d = RWB;
         EXEC_I: state_d = IWB;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   mc_outdecode u_outdecode (
      .state_i     (state_q),
      .op_i        (op),
      .mem_ready_i (bus.mem_ready),
      .ctrl_o      (ctrl)
   );

   // Gate with rst_n so an in-flight write drops the instant reset asserts
   assign ctrl_g = rst_n ? ctrl : '0;

   assign bus.PCWr       = ctrl_g.PCWr;
   assign bus.PCWrCond   = ctrl_g.PCWrCond;
   assign bus.IorD       = ctrl_g.IorD;
   assign bus.MemRd      = ctrl_g.MemRd;
   assign bus.MemWr      = ctrl_g.MemWr;
   assign bus.IRWr       = ctrl_g.IRWr;
   assign bus.RegDst     = ctrl_g.RegDst;
   assign bus.MemtoReg   = ctrl_g.MemtoReg;
   assign bus.RegWr      = ctrl_g.RegWr;
   assign bus.ALUSrcA    = ctrl_g.ALUSrcA;
   assign bus.ALUSrcB    = ctrl_g.ALUSrcB;
   assign bus.ALUop      = ctrl_g.ALUop;
   assign bus.ExtOp      = ctrl_g.ExtOp;
   assign bus.PCSrc      = ctrl_g.PCSrc;
   assign bus.R_type     = ctrl_g.R_type;
   assign bus.illegal_op = ctrl_g.illegal_op;
   assign bus.state      = rst_n ? state_q : FETCH;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: per-instruction cycle recipes feed an expectation queue,
// a negedge monitor compares every cycle's control word and state.
module tb_multicycle_control;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_EXEC_R = 6, S_RWB = 7, S_EXEC_I = 8, S_IWB = 9,
                  S_BRANCH = 10, S_JUMP = 11, S_ILLEGAL = 12;

   localparam logic [5:0] R_OP = 6'b000000, ORI = 6'b001101, ADDIU = 6'b001001,
                          LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;

   typedef struct packed {
      logic       pcwr, pcwrc, iord, memrd, memwr, irwr, regdst, memtoreg, regwr, srca;
      logic [1:0] srcb;
      logic [2:0] aluop;
      logic       extop;
      logic [1:0] pcsrc;
      logic       rtype, ill;
      logic [3:0] st;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.pcwr = bus.PCWr;       o.pcwrc = bus.PCWrCond;   o.iord = bus.IorD;
      o.memrd = bus.MemRd;     o.memwr = bus.MemWr;      o.irwr = bus.IRWr;
      o.regdst = bus.RegDst;   o.memtoreg = bus.MemtoReg; o.regwr = bus.RegWr;
      o.srca = bus.ALUSrcA;    o.srcb = bus.ALUSrcB;     o.aluop = bus.ALUop;
      o.extop = bus.ExtOp;     o.pcsrc = bus.PCSrc;      o.rtype = bus.R_type;
      o.ill = bus.illegal_op;  o.st = bus.state;
      return o;
   endfunction

   // Expected control word for one cycle of a given step
   function automatic obs_t model(int st, bit rdy, logic [5:0] op);
      obs_t o = '0;
      o.st = 4'(st);
      case (st)
         S_FETCH:   begin o.memrd = 1; o.srcb = 2'b01; o.irwr = rdy; o.pcwr = rdy; end
         S_DECODE:  begin o.srcb = 2'b11; o.extop = 1; end
         S_MEMADR:  begin o.srca = 1; o.srcb = 2'b10; o.extop = 1; end
         S_MEMRD:   begin o.memrd = 1; o.iord = 1; end
         S_MEMWB:   begin o.regwr = 1; o.memtoreg = 1; end
         S_MEMWR:   begin o.memwr = 1; o.iord = 1; end
         S_EXEC_R:  begin o.srca = 1; o.aluop = 3'b100; o.rtype = 1; end
         S_RWB:     begin o.regwr = 1; o.regdst = 1; end
         S_EXEC_I:  begin
            o.srca = 1; o.srcb = 2'b10;
            if (op == ORI) o.aluop = 3'b010; else o.extop = 1;
         end
         S_IWB:     o.regwr = 1;
         S_BRANCH:  begin o.srca = 1; o.aluop = 3'b001; o.pcwrc = 1; o.pcsrc = 2'b01; end
         S_JUMP:    begin o.pcwr = 1; o.pcsrc = 2'b10; end
         S_ILLEGAL: o.ill = 1;
         default:   o = '0;
      endcase
      return o;
   endfunction

   task automatic step(int st, bit rdy, logic [5:0] op);
      exp_q.push_back(model(st, rdy, op));
      bus.mem_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(int st, int waits, logic [5:0] op);
      for (int k = 0; k < waits; k++) step(st, 1'b0, op);
      step(st, 1'b1, op);
   endtask

   // One instruction: its state recipe with the given memory wait counts
   task automatic run_instr(logic [5:0] op, int wf, int wm);
      bus.instru = {op, 26'($urandom)};
      wait_step(S_FETCH, wf, op);
      step(S_DECODE, 1'($urandom), op);
      case (op)
         LW: begin
            step(S_MEMADR, 1'($urandom), op);
            wait_step(S_MEMRD, wm, op);
            step(S_MEMWB, 1'($urandom), op);
         end
         SW: begin
            step(S_MEMADR, 1'($urandom), op);
            wait_step(S_MEMWR, wm, op);
         end
         R_OP: begin
            step(S_EXEC_R, 1'($urandom), op);
            step(S_RWB, 1'($urandom), op);
         end
         ORI, ADDIU: begin
            step(S_EXEC_I, 1'($urandom), op);
            step(S_IWB, 1'($urandom), op);
         end
         BEQ:     step(S_BRANCH, 1'($urandom), op);
         J:       step(S_JUMP, 1'($urandom), op);
         default: step(S_ILLEGAL, 1'($urandom), op);
      endcase
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         obs_t e, a;
         e = exp_q.pop_front();
         a = sample();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_ctrl t=%0t state=%0d got=%h expected=%h", $time, e.st, a, e);
         end
      end
   end

   task automatic check_direct(string name, obs_t exp);
      obs_t a;
      a = sample();
      checks++;
      if (a !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, a, exp);
      end
   endtask

   logic [5:0] ops[7] = '{R_OP, ORI, ADDIU, LW, SW, BEQ, J};

   initial begin
      logic [5:0] op;
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      bus.instru = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1 check_direct("reset_outputs", '0);
      rst_n = 1'b1;

      run_instr(R_OP, 0, 0);
      run_instr(LW, 0, 2);
      run_instr(ORI, 0, 0);
      run_instr(ADDIU, 1, 0);
      run_instr(BEQ, 0, 0);
      run_instr(J, 2, 0);
      run_instr(6'b111111, 0, 0);
      run_instr(SW, 0, 1);

      // Abort a store while MemWr is held in a wait state
      bus.instru = {SW, 26'h0};
      step(S_FETCH, 1'b1, SW);
      step(S_DECODE, 1'b0, SW);
      step(S_MEMADR, 1'b1, SW);
      exp_q.push_back(model(S_MEMWR, 1'b0, SW));
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_direct("reset_abort_memwr", '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do op = 6'($urandom); while (op inside {R_OP, ORI, ADDIU, LW, SW, BEQ, J});
         end else begin
            op = ops[$urandom_range(0, 6)];
         end
         run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS-subset CPU. It replaces single-cycle main-control decode with a state machine that steps one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and write-back. It reads the opcode from the instruction register, drives every datapath enable and mux select, and stalls on a memory ready handshake. It sits between the IR/memory interface and the register file, ALU and PC logic.

## Interface
- No parameters. Opcodes, ALUop codes and state codes are fixed constants in the shared package.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instru  in  32  IR contents. Only [31:26] (op) is used; it is valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWr  out  1  unconditional PC write.
- PCWrCond  out  1  PC write if ALU zero (beq).
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRd  out  1  memory read request.
- MemWr  out  1  memory write request.
- IRWr  out  1  load IR from memory data.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- MemtoReg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- RegWr  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- ALUop  out  3  000 = add, 001 = sub, 010 = or, 100 = R-type (use func).
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend.
- PCSrc  out  2  next PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- R_type  out  1  high in EXEC_R.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- state  out  4  current state, for debug.

## Operation
- Supported opcodes:
  - R = 000000
  - ori = 001101
  - addiu = 001001
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - j = 000010
- FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=add, PCSrc=00.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: IRWr=1 and PCWr=1 in the same cycle (Mealy-qualified), then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUop=add (branch target into ALUOut). Next state by op:
  - lw/sw → MEMADR
  - R → EXEC_R
  - ori/addiu → EXEC_I
  - beq → BRANCH
  - j → JUMP
  - anything else → ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUop=add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRd=1, IorD=1. Stays while mem_ready=0; on ready → MEMWB.
- MEMWB: RegWr=1, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: MemWr=1, IorD=1. Stays while mem_ready=0; on ready → FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=100, R_type=1 → RWB.
- RWB: RegWr=1, RegDst=1, MemtoReg=0 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ori: ExtOp=0, ALUop=or. addiu: ExtOp=1, ALUop=add. → IWB.
- IWB: RegWr=1, RegDst=0, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=sub, PCWrCond=1, PCSrc=01 → FETCH.
- JUMP: PCWr=1, PCSrc=10 → FETCH.
- ILLEGAL: illegal_op=1, no write enables → FETCH. The PC is already advanced, so the instruction is skipped.
- Any output not listed for a state is 0.
- Every write enable (PCWr, PCWrCond, IRWr, RegWr, MemWr) is asserted at most one cycle per instruction, except MemWr, which is held through wait states.

## Timing
- Reset:
  - State goes to FETCH asynchronously.
  - While rst_n=0, all outputs are 0. This includes MemRd: outputs are gated by reset.
  - On the first clk edge after release, normal FETCH decode applies.
- Reset mid-instruction aborts it immediately. Pending RegWr/MemWr drop in the same cycle (async) and no partial write commits.
- Instruction latency with mem_ready tied high:
  - lw: 5 cycles
  - R, ori, addiu, sw: 4 cycles
  - beq, j: 3 cycles
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Request signals stay stable during wait.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- The state register updates on the rising clk edge only. Outputs are combinational from state, plus mem_ready for IRWr/PCWr in FETCH.

## Structure
- Package mc_pkg holds:
  - state enum, 4-bit: FETCH=0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, ILLEGAL
  - opcode constants
  - ALUop codes
  - ALUSrcB and PCSrc select codes
- Sub-module mc_outdecode: purely combinational map of (state, op, mem_ready) to control outputs.
- The top holds the state register and next-state logic.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 → all outputs 0, state=0. Release → MemRd=1, IRWr=1, PCWr=1 in the first cycle.
- R-type (op 000000, func 100000), mem_ready=1 → states FETCH, DECODE, EXEC_R, RWB. R_type=1 and ALUop=100 in EXEC_R; RegWr=1 and RegDst=1 in RWB only.
- lw (100011) with mem_ready low for 2 cycles in MEMRD → MemRd=1 and IorD=1 held for 3 cycles, then MEMWB with RegWr=1 and MemtoReg=1; total 7 cycles.
- ori (001101) → ExtOp=0 and ALUop=010 in EXEC_I. addiu (001001) → ExtOp=1 and ALUop=000.
- beq (000100) → PCWrCond=1, PCSrc=01, ALUop=001 in cycle 3. j (000010) → PCWr=1 and PCSrc=10 in cycle 3. Both return to FETCH.
- Opcode 111111 → illegal_op pulses for one cycle, then FETCH. Assert rst_n low during sw MEMWR → MemWr=0 immediately.
